// File: rtl/expand.sv
// -----------------------------------------------------------------------------
// expand
//
// Widens a narrow fixed-point sample into a wider fixed-point word without
// changing its numeric value. The integer part is sign- or zero-extended on
// the left, and the fraction is zero-padded on the right. Converted words pass
// through a two-entry elastic buffer with valid/ready handshakes on both
// sides, so the block can stream one word per cycle and still absorb
// back-pressure.
//
// Parameters
//   N_BITS_IN  : input word width
//   BIN_PT_IN  : fractional bits in din
//   N_BITS_OUT : output word width
//   BIN_PT_OUT : fractional bits in dout
//   SIGNED     : 1 = two's-complement sign extension, 0 = zero extension
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   din_valid  : din carries a word to transfer
//   din_ready  : block can take a word this cycle (registered)
//   din        : narrow fixed-point sample
//   dout_valid : dout carries a converted word (registered)
//   dout_ready : downstream takes dout this cycle
//   dout       : oldest stored converted word (registered)
//   mode       : constant conversion class code derived from the parameters
//   count      : number of output transfers since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module expand #(
  parameter int N_BITS_IN  = 4,
  parameter int BIN_PT_IN  = 3,
  parameter int N_BITS_OUT = 10,
  parameter int BIN_PT_OUT = 7,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [N_BITS_IN-1:0]  din,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [N_BITS_OUT-1:0] dout,
  output logic [4:0]            mode,
  output logic [15:0]           count
);

  // Bit positions of the most and least significant bits of each format.
  // The LSB index is negative for fractional bits. MSBS is the number of bits
  // added above the input MSB. LSBS is the number of bits added below the
  // input LSB.
  localparam int MSB_IN  = N_BITS_IN - BIN_PT_IN - 1;
  localparam int LSB_IN  = -BIN_PT_IN;
  localparam int MSB_OUT = N_BITS_OUT - BIN_PT_OUT - 1;
  localparam int LSB_OUT = -BIN_PT_OUT;
  localparam int MSBS    = MSB_OUT - MSB_IN;
  localparam int LSBS    = LSB_IN - LSB_OUT;

  // This block can only widen. A format pair that would drop bits on either
  // end is rejected at elaboration.
  generate
    if ((MSBS < 0) || (LSBS < 0)) begin : g_narrowing_rejected
      $error("expand: output format must contain the input format (MSBS=%0d, LSBS=%0d)",
             MSBS, LSBS);
    end
  endgenerate

  // The conversion class depends only on the parameters.
  // Bit 0 flags left extension and bit 1 flags right padding.
  localparam logic [4:0] MODE_CODE = 5'(((MSBS > 0) ? 1 : 0) + ((LSBS > 0) ? 2 : 0));

  assign mode = MODE_CODE;

  // ---------------------------------------------------------------------------
  // Conversion
  // ---------------------------------------------------------------------------
  logic                  ext;
  logic [N_BITS_OUT-1:0] conv;

  assign ext = (SIGNED != 0) ? din[N_BITS_IN-1] : 1'b0;

  // First extend the input by MSBS+LSBS copies of ext. Then shift it left by
  // LSBS. The top LSBS extension bits fall off, and zeros fill the bottom.
  // This builds {MSBS x ext, din, LSBS x 0} without a zero-width
  // replication when either count is zero.
  generate
    if (N_BITS_OUT == N_BITS_IN) begin : g_same_width
      assign conv = din;
    end else begin : g_widen
      logic [N_BITS_OUT-1:0] extWord;
      assign extWord = {{(N_BITS_OUT - N_BITS_IN){ext}}, din};
      assign conv    = extWord << LSBS;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Two-entry elastic buffer
  // ---------------------------------------------------------------------------
  // headQ always holds the oldest word and drives dout directly, so the
  // output is a plain register. tailQ is only used when both entries are full.
  logic [N_BITS_OUT-1:0] head_q, head_d;
  logic [N_BITS_OUT-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rdy_q, rdy_d;
  logic                  vld_q, vld_d;
  logic [15:0]           count_q, count_d;
  logic                  push;
  logic                  pop;

  // Both handshakes use only registered flags.
  // This keeps dout_ready off any path to din_ready.
  assign push = din_valid & rdy_q;
  assign pop  = vld_q & dout_ready;

  // Next-state logic for the buffer contents and occupancy.
  // When a push and a pop happen together, the departing head is replaced so
  // FIFO order is kept and occupancy does not change.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    count_d = count_q;

    if (push && pop) begin
      if (occ_q == 2'd2) begin
        head_d = tail_q;
        tail_d = conv;
      end else begin
        head_d = conv;
      end
    end else if (push) begin
      if (occ_q == 2'd0) begin
        head_d = conv;
      end else begin
        tail_d = conv;
      end
      occ_d = occ_q + 2'd1;
    end else if (pop) begin
      if (occ_q == 2'd2) begin
        head_d = tail_q;
      end
      occ_d = occ_q - 2'd1;
    end

    if (pop) begin
      count_d = count_q + 16'd1;
    end
  end

  // The handshake flags are registered versions of the next occupancy.
  // A pop at full therefore raises din_ready on the very next cycle.
  always_comb begin
    rdy_d = (occ_d != 2'd2);
    vld_d = (occ_d != 2'd0);
  end

  // State registers. Reset takes priority over any transfer in the same
  // cycle, so stored words are discarded and the final pop is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  assign din_ready  = rdy_q;
  assign dout_valid = vld_q;
  assign dout       = head_q;
  assign count      = count_q;

endmodule

// File: tb/tb_expand.sv
// -----------------------------------------------------------------------------
// tb_expand
//
// Directed bench for expand. There are three instances:
//   dut    : default parameters (signed 4.3 -> 10.7)
//   dutU   : same formats with SIGNED=0
//   dutId  : 8.7 -> 8.7 identity conversion
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_expand;

  logic clk = 1'b0;
  logic rst;

  // Default instance
  logic       dinValid, dinReady, doutValid, doutReady;
  logic [3:0] din;
  logic [9:0] dout;
  logic [4:0] mode;
  logic [15:0] count;

  // Unsigned instance
  logic       uDinValid, uDinReady, uDoutValid, uDoutReady;
  logic [3:0] uDin;
  logic [9:0] uDout;
  logic [4:0] uMode;
  logic [15:0] uCount;

  // Identity instance
  logic       iDinValid, iDinReady, iDoutValid, iDoutReady;
  logic [7:0] iDin;
  logic [7:0] iDout;
  logic [4:0] iMode;
  logic [15:0] iCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  expand dut (
    .clk(clk), .rst(rst),
    .din_valid(dinValid), .din_ready(dinReady), .din(din),
    .dout_valid(doutValid), .dout_ready(doutReady), .dout(dout),
    .mode(mode), .count(count)
  );

  expand #(.SIGNED(0)) dutU (
    .clk(clk), .rst(rst),
    .din_valid(uDinValid), .din_ready(uDinReady), .din(uDin),
    .dout_valid(uDoutValid), .dout_ready(uDoutReady), .dout(uDout),
    .mode(uMode), .count(uCount)
  );

  expand #(.N_BITS_IN(8), .BIN_PT_IN(7), .N_BITS_OUT(8), .BIN_PT_OUT(7)) dutId (
    .clk(clk), .rst(rst),
    .din_valid(iDinValid), .din_ready(iDinReady), .din(iDin),
    .dout_valid(iDoutValid), .dout_ready(iDoutReady), .dout(iDout),
    .mode(iMode), .count(iCount)
  );

  // Reference conversion for the signed default format.
  // The value is sign-extended by two bits and then padded with four zeros.
  function automatic logic [9:0] refSigned(input logic [3:0] d);
    return {d[3], d[3], d, 4'b0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Check the reset state of all three instances.
  task automatic test_reset();
    dinValid = 0; doutReady = 1; din = 4'h0;
    uDinValid = 0; uDoutReady = 1; uDin = 4'h0;
    iDinValid = 0; iDoutReady = 1; iDin = 8'h00;
    doReset();
    checks++;
    if (doutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout_valid got=%b exp=0", doutValid); end
    checks++;
    if (dout !== 10'd0) begin errors++; $display("[TB] FAIL reset_dout got=%h exp=000", dout); end
    checks++;
    if (count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (dinReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_din_ready got=%b exp=1", dinReady); end
    checks++;
    if (mode !== 5'd3) begin errors++; $display("[TB] FAIL mode_default got=%0d exp=3", mode); end
    checks++;
    if (iMode !== 5'd0) begin errors++; $display("[TB] FAIL mode_identity got=%0d exp=0", iMode); end
  endtask

  // Check signed conversion of a negative value, then a positive one.
  task automatic test_signed();
    dinValid = 1; din = 4'b1010;
    tick();
    checks++;
    if (dout !== 10'b11_1010_0000) begin errors++; $display("[TB] FAIL signed_neg got=%b exp=1110100000", dout); end
    checks++;
    if (doutValid !== 1'b1) begin errors++; $display("[TB] FAIL signed_neg_valid got=%b exp=1", doutValid); end
    din = 4'b0111;
    tick();
    checks++;
    if (dout !== 10'b00_0111_0000) begin errors++; $display("[TB] FAIL signed_pos got=%b exp=0001110000", dout); end
    dinValid = 0;
    tick();
    checks++;
    if (doutValid !== 1'b0) begin errors++; $display("[TB] FAIL signed_drain got=%b exp=0", doutValid); end
    checks++;
    if (count !== 16'd2) begin errors++; $display("[TB] FAIL signed_count got=%0d exp=2", count); end
  endtask

  // Check zero extension with SIGNED=0.
  task automatic test_unsigned();
    uDinValid = 1; uDin = 4'b1010;
    tick();
    checks++;
    if (uDout !== 10'b00_1010_0000) begin errors++; $display("[TB] FAIL unsigned_a got=%b exp=0010100000", uDout); end
    uDin = 4'b0111;
    tick();
    checks++;
    if (uDout !== 10'b00_0111_0000) begin errors++; $display("[TB] FAIL unsigned_b got=%b exp=0001110000", uDout); end
    uDinValid = 0;
    tick();
    checks++;
    if (uMode !== 5'd3) begin errors++; $display("[TB] FAIL unsigned_mode got=%0d exp=3", uMode); end
  endtask

  // Check that the identity formats give the input delayed by one cycle.
  task automatic test_identity();
    iDinValid = 1; iDin = 8'h5A;
    tick();
    checks++;
    if (iDout !== 8'h5A) begin errors++; $display("[TB] FAIL identity_a got=%h exp=5a", iDout); end
    iDin = 8'h80;
    tick();
    checks++;
    if (iDout !== 8'h80) begin errors++; $display("[TB] FAIL identity_b got=%h exp=80", iDout); end
    iDinValid = 0;
    tick();
  endtask

  // Check back-pressure: three inputs arrive while dout_ready is low.
  task automatic test_backpressure();
    doReset();
    doutReady = 0;
    dinValid = 1; din = 4'h1;
    tick();
    checks++;
    if (dinReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after_a got=%b exp=1", dinReady); end
    din = 4'h2;
    tick();
    checks++;
    if (dinReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_full got=%b exp=0", dinReady); end
    din = 4'h3;
    tick();
    checks++;
    if (dout !== 10'h010) begin errors++; $display("[TB] FAIL bp_stable got=%h exp=010", dout); end
    checks++;
    if (dinReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_still_full got=%b exp=0", dinReady); end
    doutReady = 1;
    tick();
    checks++;
    if (dout !== 10'h020) begin errors++; $display("[TB] FAIL bp_out_b got=%h exp=020", dout); end
    checks++;
    if (dinReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_return got=%b exp=1", dinReady); end
    tick();
    checks++;
    if (dout !== 10'h030) begin errors++; $display("[TB] FAIL bp_out_c got=%h exp=030", dout); end
    dinValid = 0;
    tick();
    checks++;
    if (doutValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained got=%b exp=0", doutValid); end
    checks++;
    if (count !== 16'd3) begin errors++; $display("[TB] FAIL bp_count got=%0d exp=3", count); end
  endtask

  // Fill the buffer, then reset in the same cycle that dout_ready is high.
  task automatic test_reset_mid();
    doutReady = 0;
    dinValid = 1; din = 4'h5;
    tick();
    din = 4'h6;
    tick();
    checks++;
    if (dinReady !== 1'b0) begin errors++; $display("[TB] FAIL mid_full got=%b exp=0", dinReady); end
    dinValid = 0; doutReady = 1; rst = 1;
    tick();
    rst = 0;
    checks++;
    if (doutValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got=%b exp=0", doutValid); end
    checks++;
    if (count !== 16'd0) begin errors++; $display("[TB] FAIL mid_count got=%0d exp=0", count); end
    checks++;
    if (dinReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got=%b exp=1", dinReady); end
    tick();
    checks++;
    if (doutValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_discard got=%b exp=0", doutValid); end
  endtask

  // Stream 70000 words back to back. The count must wrap to 70000 mod 65536.
  task automatic test_back_to_back();
    int bad;
    logic [3:0] w;
    bad = 0;
    doReset();
    doutReady = 1;
    dinValid = 1;
    for (int i = 0; i < 70000; i++) begin
      w = 4'(i);
      din = w;
      tick();
      if (dout !== refSigned(w) || doutValid !== 1'b1 || dinReady !== 1'b1) bad++;
    end
    dinValid = 0;
    tick();
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL stream_cycles bad_cycles=%0d exp=0", bad); end
    checks++;
    if (count !== 16'd4464) begin errors++; $display("[TB] FAIL stream_count got=%0d exp=4464", count); end
    checks++;
    if (doutValid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain got=%b exp=0", doutValid); end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_signed();
    test_unsigned();
    test_identity();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
